// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst reader that absorbs RAM read latency and streams words out through a credit-limited FIFO.
module ram_stream_reader #(
   parameter int DW = 8,
   parameter int MD = 1024,
   parameter int AW = $clog2(MD),
   parameter int RD_LAT = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_adr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic          ram_clk_en,
   output logic          ram_rd,
   output logic [AW-1:0] ram_adr,
   input  logic [DW-1:0] ram_dat,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [DW-1:0] out_dat,
   output logic          out_last
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1);
   if (RD_LAT < 1 || RD_LAT > 2 || FIFO_DEPTH < RD_LAT + 1)
      $error("ram_stream_reader: illegal RD_LAT/FIFO_DEPTH combination");
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   state_t state, state_nx;
   logic [AW:0] len_q, iss_cnt, pop_cnt;
   logic [RD_LAT-1:0] sr;
   logic [DW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wp, rp;
   logic [CW-1:0] cnt, infl;
   logic zero_done, accept, go, push, pop, fin;
   assign ram_clk_en = 1'b1;
   assign accept = start && state == IDLE && !done;
   assign go = accept && len != '0;
   assign infl = CW'($countones(sr));
   assign push = sr[RD_LAT-1];
   assign out_vld = cnt != '0;
   assign pop = out_vld && out_rdy;
   assign out_dat = mem[rp];
   assign out_last = out_vld && pop_cnt == len_q - (AW+1)'(1);
   always_comb begin
      ram_rd = state == ISSUE && infl + cnt < CW'(FIFO_DEPTH);
      fin = state == DRAIN && pop && out_last;
      state_nx = go ? ISSUE : ram_rd && iss_cnt + (AW+1)'(1) == len_q ? DRAIN : fin ? IDLE : state;
      done = zero_done || fin;
      busy = state != IDLE && !fin;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         zero_done <= 1'b0;
         len_q <= '0;
         iss_cnt <= '0;
         pop_cnt <= '0;
         ram_adr <= '0;
         sr <= '0;
         wp <= '0;
         rp <= '0;
         cnt <= '0;
      end else begin
         state <= state_nx;
         zero_done <= accept && len == '0;
         if (go) begin
            len_q <= len;
            iss_cnt <= '0;
            pop_cnt <= '0;
            ram_adr <= base_adr;
         end else begin
            if (ram_rd) begin
               iss_cnt <= iss_cnt + (AW+1)'(1);
               ram_adr <= ram_adr == AW'(MD - 1) ? '0 : ram_adr + AW'(1);
            end
            if (pop) pop_cnt <= pop_cnt + (AW+1)'(1);
         end
         sr <= RD_LAT'({sr, ram_rd});
         if (push) wp <= wp == PW'(FIFO_DEPTH - 1) ? '0 : wp + PW'(1);
         if (pop) rp <= rp == PW'(FIFO_DEPTH - 1) ? '0 : rp + PW'(1);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   always_ff @(posedge clk)
      if (rst) for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      else if (push) mem[wp] <= ram_dat;
   always_ff @(posedge clk)
      if (!rst && push && !pop) assert (cnt < CW'(FIFO_DEPTH));
endmodule
